// File: rtl/core_pkg.sv
// Shared register-file types and helpers for the integer core.
package core_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      RF_SWEEP = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   // True for an architecturally implemented, writable register (not x0, below nregs).
   function automatic logic reg_in_range(input logic [REG_ADDR_W-1:0] a, input int nregs);
      return (a != ZERO_REG) && (int'(a) < nregs);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared on writeback,
// all cleared on flush or while the register file is not running.
module rf_scoreboard
   import core_pkg::*;
#(
   parameter int NREGS = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   input  logic                  clr_valid,
   input  logic [REG_ADDR_W-1:0] clr_rd,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] a1,
   input  logic [REG_ADDR_W-1:0] a2,
   input  logic                  mask1,
   input  logic                  mask2,
   output logic                  hazard
);

   localparam int IDX_W = $clog2(NREGS);

   logic [NREGS-1:0] busy;

   function automatic logic [IDX_W-1:0] idx(input logic [REG_ADDR_W-1:0] a);
      return a[IDX_W-1:0];
   endfunction

   // Busy update: flush beats everything, and a same-cycle issue beats the writeback clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else if (!run || flush) begin
         busy <= '0;
      end else begin
         if (clr_valid && reg_in_range(clr_rd, NREGS)) busy[idx(clr_rd)] <= 1'b0;
         if (iss_valid && reg_in_range(iss_rd, NREGS)) busy[idx(iss_rd)] <= 1'b1;
      end
   end

   // Hazard from current busy state; operand terms can be masked when bypass will supply the value.
   always_comb begin
      hazard = 1'b0;
      if (reg_in_range(a1, NREGS) && busy[idx(a1)] && !mask1) hazard = 1'b1;
      if (reg_in_range(a2, NREGS) && busy[idx(a2)] && !mask2) hazard = 1'b1;
      if (reg_in_range(iss_rd, NREGS) && busy[idx(iss_rd)]) hazard = 1'b1;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with busy scoreboard and post-reset zero-sweep.
// state    | meaning
// RF_SWEEP | clearing reg[1..NREGS-1] one per cycle; reads return 0, writes/issues ignored
// RF_RUN   | normal operation; ready=1
module regfile_scoreboard
   import core_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = 16,
   parameter bit BYPASS = 1'b1
) (
   input  logic                  CLK,
   input  logic                  reset_n,
   input  logic [REG_ADDR_W-1:0] A1,
   input  logic [REG_ADDR_W-1:0] A2,
   output logic [XLEN-1:0]       RD1,
   output logic [XLEN-1:0]       RD2,
   input  logic [REG_ADDR_W-1:0] A3,
   input  logic                  WE3,
   input  logic [XLEN-1:0]       WD3,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   input  logic                  flush,
   output logic                  hazard,
   output logic                  ready
);

   localparam int IDX_W = $clog2(NREGS);

   rf_state_t        state;
   logic [IDX_W-1:0] sweep_idx;
   logic [XLEN-1:0]  regs [NREGS];
   logic             mask1;
   logic             mask2;

   // Sweep FSM: walks indices 1..NREGS-1 and then settles in RUN.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RF_SWEEP;
         sweep_idx <= IDX_W'(1);
         ready     <= 1'b0;
      end else begin
         case (state)
            RF_SWEEP: begin
               sweep_idx <= sweep_idx + 1'b1;
               if (sweep_idx == IDX_W'(NREGS - 1)) begin
                  state <= RF_RUN;
                  ready <= 1'b1;
               end
            end
            RF_RUN: ready <= 1'b1;
            default: begin
               state <= RF_SWEEP;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset; the sweep provides the known-zero starting contents.
   always_ff @(posedge CLK) begin
      if (state == RF_SWEEP) begin
         regs[sweep_idx] <= '0;
      end else if (WE3 && reg_in_range(A3, NREGS)) begin
         regs[A3[IDX_W-1:0]] <= WD3;
      end
   end

   function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] a);
      if (!ready || !reg_in_range(a, NREGS)) return '0;
      if (BYPASS && WE3 && (A3 == a)) return WD3;
      return regs[a[IDX_W-1:0]];
   endfunction

   // Asynchronous read ports with optional writeback bypass.
   always_comb begin
      RD1   = read_port(A1);
      RD2   = read_port(A2);
      mask1 = BYPASS && WE3 && (A3 == A1);
      mask2 = BYPASS && WE3 && (A3 == A2);
   end

   rf_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk       (CLK),
      .rst_n     (reset_n),
      .run       (ready),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .clr_valid (WE3),
      .clr_rd    (A3),
      .flush     (flush),
      .a1        (A1),
      .a2        (A2),
      .mask1     (mask1),
      .mask2     (mask2),
      .hazard    (hazard)
   );

endmodule
